// File: rtl/hidden_stream_probe_if.sv
// Bundle of NUM_CH Avalon-ST style streams (valid/data/sop/eop) observed by the probe.
// The master drives the streams; the probe only ever listens on the slave side.
interface hidden_stream_probe_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        startofpacket;
    logic [NUM_CH-1:0]        endofpacket;

    modport master (output valid, data, startofpacket, endofpacket);
    modport slave  (input  valid, data, startofpacket, endofpacket);
endinterface

// File: rtl/hidden_stream_probe.sv
// Passive multi-channel stream probe: per-channel framing checker and packet stats,
// plus a circular capture buffer on one selected channel that freezes on a framing error.
module hidden_stream_probe #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    parameter  int CNT_W  = 16,
    parameter  int LEN_W  = 12,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    hidden_stream_probe_if.slave    st_i,
    input  logic                    clear_i,
    input  logic [CH_W-1:0]         cap_sel_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [NUM_CH-1:0]       in_packet_o,
    output logic [NUM_CH*CNT_W-1:0] pkt_count_o,
    output logic [NUM_CH*LEN_W-1:0] last_len_o,
    output logic [NUM_CH*3-1:0]     err_sticky_o,
    output logic                    frozen_o,
    output logic [AW-1:0]           cap_wr_ptr_o,
    output logic [DATA_W+1:0]       rd_data_o
);
    localparam logic [0:0]       ST_IDLE = 1'b0;
    localparam logic [0:0]       ST_PKT  = 1'b1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [NUM_CH-1:0] beat_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [0:0]       state_q, state_d;
        logic [LEN_W-1:0] len_q, len_d, last_q, last_d, len_inc;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [2:0]       err_q, err_d;
        logic             v, sop, eop, berr;

        assign v       = st_i.valid[gi];
        assign sop     = st_i.startofpacket[gi];
        assign eop     = st_i.endofpacket[gi];
        assign len_inc = (len_q == LEN_MAX) ? LEN_MAX : len_q + 1'b1;

        always_comb begin
            state_d = state_q;
            len_d   = len_q;
            last_d  = last_q;
            cnt_d   = cnt_q;
            err_d   = err_q;
            berr    = 1'b0;
            if (clear_i) begin
                state_d = ST_IDLE;
                len_d   = '0;
                last_d  = '0;
                cnt_d   = '0;
                err_d   = '0;
            end else if (v) begin
                if (state_q == ST_IDLE) begin
                    if (sop) begin
                        if (eop) begin
                            cnt_d  = cnt_q + 1'b1;
                            last_d = LEN_ONE;
                        end else begin
                            state_d = ST_PKT;
                            len_d   = LEN_ONE;
                        end
                    end else begin
                        berr = 1'b1;
                        if (eop) err_d[1] = 1'b1;
                        else     err_d[2] = 1'b1;
                    end
                end else begin
                    if (sop) begin
                        // A sop mid-packet drops the open packet and starts over.
                        berr     = 1'b1;
                        err_d[0] = 1'b1;
                        if (eop) begin
                            cnt_d   = cnt_q + 1'b1;
                            last_d  = LEN_ONE;
                            state_d = ST_IDLE;
                            len_d   = '0;
                        end else begin
                            len_d = LEN_ONE;
                        end
                    end else if (eop) begin
                        cnt_d   = cnt_q + 1'b1;
                        last_d  = len_inc;
                        state_d = ST_IDLE;
                        len_d   = '0;
                    end else begin
                        len_d = len_inc;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                len_q   <= '0;
                last_q  <= '0;
                cnt_q   <= '0;
                err_q   <= '0;
            end else begin
                state_q <= state_d;
                len_q   <= len_d;
                last_q  <= last_d;
                cnt_q   <= cnt_d;
                err_q   <= err_d;
            end
        end

        assign beat_err[gi]                     = berr;
        assign in_packet_o[gi]                  = (state_q == ST_PKT);
        assign pkt_count_o[gi*CNT_W +: CNT_W]   = cnt_q;
        assign last_len_o[gi*LEN_W +: LEN_W]    = last_q;
        assign err_sticky_o[gi*3 +: 3]          = err_q;
    end

    logic              sel_valid, sel_sop, sel_eop, sel_err;
    logic [DATA_W-1:0] sel_data;
    logic              wr_en;
    logic              frozen_q, frozen_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [DATA_W+1:0] rd_data_q;
    logic [DATA_W+1:0] mem [DEPTH];

    // Explicit mux so an out-of-range cap_sel simply selects nothing.
    always_comb begin
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_err   = 1'b0;
        sel_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(cap_sel_i) == c) begin
                sel_valid = st_i.valid[c];
                sel_sop   = st_i.startofpacket[c];
                sel_eop   = st_i.endofpacket[c];
                sel_err   = beat_err[c];
                sel_data  = st_i.data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_en = !clear_i && !frozen_q && sel_valid;

    always_comb begin
        ptr_d    = ptr_q;
        frozen_d = frozen_q;
        if (clear_i) begin
            ptr_d    = '0;
            frozen_d = 1'b0;
        end else if (wr_en) begin
            ptr_d    = ptr_q + 1'b1;
            frozen_d = sel_err;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr_q] <= {sel_sop, sel_eop, sel_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            frozen_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            frozen_q  <= frozen_d;
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign frozen_o     = frozen_q;
    assign cap_wr_ptr_o = ptr_q;
    assign rd_data_o    = rd_data_q;
endmodule

// File: tb/tb_hidden_stream_probe.sv
// Self-checking bench for hidden_stream_probe: vector table, directed corner sequences
// and a randomized phase, all compared against a behavioural packet/capture model.
module tb_hidden_stream_probe;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 8;
    localparam int LEN_W  = 4;
    localparam int CH_W   = 2;
    localparam int AW     = 6;
    localparam int LMAX   = (1 << LEN_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic [CH_W-1:0]         cap_sel;
    logic [AW-1:0]           rd_addr;
    logic [NUM_CH-1:0]       in_packet;
    logic [NUM_CH*CNT_W-1:0] pkt_count;
    logic [NUM_CH*LEN_W-1:0] last_len;
    logic [NUM_CH*3-1:0]     err_sticky;
    logic                    frozen;
    logic [AW-1:0]           cap_wr_ptr;
    logic [DATA_W+1:0]       rd_data;

    always #5 clk = ~clk;

    hidden_stream_probe_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) sif ();

    hidden_stream_probe #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .st_i(sif), .clear_i(clear), .cap_sel_i(cap_sel),
        .rd_addr_i(rd_addr), .in_packet_o(in_packet), .pkt_count_o(pkt_count),
        .last_len_o(last_len), .err_sticky_o(err_sticky), .frozen_o(frozen),
        .cap_wr_ptr_o(cap_wr_ptr), .rd_data_o(rd_data)
    );

    // Behavioural model state
    bit                m_open [NUM_CH];
    int                m_len  [NUM_CH];
    int                m_cnt  [NUM_CH];
    int                m_last [NUM_CH];
    bit [2:0]          m_err  [NUM_CH];
    logic [DATA_W+1:0] m_mem  [DEPTH];
    bit                m_wr   [DEPTH];
    int                m_ptr;
    bit                m_frozen;
    logic [DATA_W+1:0] m_rd;
    bit                m_rd_known;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit       v, s, e;
        bit       ip;
        int       cnt, len;
        bit [2:0] err;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_open[c] = 0; m_len[c] = 0; m_cnt[c] = 0; m_last[c] = 0; m_err[c] = 0;
        end
        m_ptr = 0;
        m_frozen = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_rd = '0;
        m_rd_known = 1;
    endtask

    task automatic count_pkt(input int c, input int len);
        m_cnt[c]  = (m_cnt[c] + 1) % (1 << CNT_W);
        m_last[c] = (len > LMAX) ? LMAX : len;
        m_open[c] = 0;
        m_len[c]  = 0;
    endtask

    // Applies the beat sampled at the current rising edge to the model.
    task automatic model_edge();
        bit [NUM_CH-1:0] err_now;
        bit v, s, e;
        m_rd_known = m_wr[rd_addr];
        m_rd       = m_mem[rd_addr];
        err_now    = '0;
        if (clear) begin
            model_clear();
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            v = sif.valid[c]; s = sif.startofpacket[c]; e = sif.endofpacket[c];
            if (!v) continue;
            if (!m_open[c]) begin
                if (s && e)  count_pkt(c, 1);
                else if (s) begin m_open[c] = 1; m_len[c] = 1; end
                else begin
                    err_now[c] = 1;
                    if (e) m_err[c][1] = 1; else m_err[c][2] = 1;
                end
            end else if (s) begin
                err_now[c] = 1;
                m_err[c][0] = 1;
                if (e) count_pkt(c, 1);
                else   m_len[c] = 1;
            end else if (e) begin
                count_pkt(c, m_len[c] + 1);
            end else begin
                m_len[c] = (m_len[c] + 1 > LMAX) ? LMAX : m_len[c] + 1;
            end
        end
        if (!m_frozen && sif.valid[cap_sel]) begin
            m_mem[m_ptr] = {sif.startofpacket[cap_sel], sif.endofpacket[cap_sel],
                            sif.data[cap_sel*DATA_W +: DATA_W]};
            m_wr[m_ptr] = 1;
            m_ptr = (m_ptr + 1) % DEPTH;
            if (err_now[cap_sel]) m_frozen = 1;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("in_packet[%0d]", c), 64'(in_packet[c]), 64'(m_open[c]));
            chk($sformatf("pkt_count[%0d]", c), 64'(pkt_count[c*CNT_W +: CNT_W]), 64'(m_cnt[c]));
            chk($sformatf("last_len[%0d]", c), 64'(last_len[c*LEN_W +: LEN_W]), 64'(m_last[c]));
            chk($sformatf("err_sticky[%0d]", c), 64'(err_sticky[c*3 +: 3]), 64'(m_err[c]));
        end
        chk("frozen", 64'(frozen), 64'(m_frozen));
        chk("cap_wr_ptr", 64'(cap_wr_ptr), 64'(m_ptr));
        if (m_rd_known) chk("rd_data", 64'(rd_data), 64'(m_rd));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        sif.valid = '0;
        sif.startofpacket = '0;
        sif.endofpacket = '0;
        sif.data = '0;
    endtask

    task automatic beat(input int c, input bit s, input bit e, input logic [DATA_W-1:0] d);
        set_idle();
        sif.valid[c] = 1'b1;
        sif.startofpacket[c] = s;
        sif.endofpacket[c] = e;
        sif.data[c*DATA_W +: DATA_W] = d;
        step();
    endtask

    task automatic pulse_clear();
        set_idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        //            v  s  e  ip cnt len err
        tbl[0]  = '{1, 1, 0, 1, 0, 0, 3'b000};
        tbl[1]  = '{1, 0, 0, 1, 0, 0, 3'b000};
        tbl[2]  = '{1, 0, 0, 1, 0, 0, 3'b000};
        tbl[3]  = '{1, 0, 1, 0, 1, 4, 3'b000};
        tbl[4]  = '{0, 1, 1, 0, 1, 4, 3'b000};
        tbl[5]  = '{1, 1, 1, 0, 2, 1, 3'b000};
        tbl[6]  = '{1, 0, 1, 0, 2, 1, 3'b010};
        tbl[7]  = '{1, 0, 0, 0, 2, 1, 3'b110};
        tbl[8]  = '{1, 1, 0, 1, 2, 1, 3'b110};
        tbl[9]  = '{1, 1, 0, 1, 2, 1, 3'b111};
        tbl[10] = '{1, 0, 1, 0, 3, 2, 3'b111};

        for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
        rst = 1'b1; clear = 1'b0; cap_sel = '0; rd_addr = '0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Channel 0 framing vectors
        for (int i = 0; i < 11; i++) begin
            set_idle();
            sif.valid[0] = tbl[i].v;
            sif.startofpacket[0] = tbl[i].s;
            sif.endofpacket[0] = tbl[i].e;
            sif.data[31:0] = 32'(i);
            step();
            chk($sformatf("tbl%0d.in_packet", i), 64'(in_packet[0]), 64'(tbl[i].ip));
            chk($sformatf("tbl%0d.pkt_count", i), 64'(pkt_count[CNT_W-1:0]), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d.last_len", i), 64'(last_len[LEN_W-1:0]), 64'(tbl[i].len));
            chk($sformatf("tbl%0d.err", i), 64'(err_sticky[2:0]), 64'(tbl[i].err));
        end

        // Channel 1 counter wrap
        for (int i = 0; i < (1 << CNT_W) + 3; i++) beat(1, 1, 1, 32'(i));
        chk("ch1_wrap_count", 64'(pkt_count[CNT_W +: CNT_W]), 64'd3);
        chk("ch1_wrap_len", 64'(last_len[LEN_W +: LEN_W]), 64'd1);

        // Channel 2 restart
        beat(2, 1, 0, 0); beat(2, 0, 0, 1); beat(2, 1, 0, 2); beat(2, 0, 1, 3);
        chk("ch2_err", 64'(err_sticky[6 +: 3]), 64'b001);
        chk("ch2_count", 64'(pkt_count[2*CNT_W +: CNT_W]), 64'd1);
        chk("ch2_len", 64'(last_len[2*LEN_W +: LEN_W]), 64'd2);

        // Capture wrap on channel 3, also exercising length saturation
        pulse_clear();
        cap_sel = 2'd3;
        for (int i = 0; i < 70; i++) beat(3, i == 0, i == 69, 32'(i));
        chk("cap_wrap_ptr", 64'(cap_wr_ptr), 64'd6);
        chk("ch3_len_sat", 64'(last_len[3*LEN_W +: LEN_W]), 64'(LMAX));
        set_idle();
        rd_addr = 6'd5;
        step();
        chk("rd_addr5", 64'(rd_data), {30'd0, 2'b01, 32'd69});
        rd_addr = 6'd6;
        step();
        chk("rd_addr6", 64'(rd_data), {30'd0, 2'b00, 32'd6});

        // Freeze on error and release by clear
        pulse_clear();
        for (int i = 0; i < 9; i++) beat(3, 1, 1, 32'(i));
        beat(3, 0, 1, 32'd9);
        chk("freeze_flag", 64'(frozen), 64'd1);
        chk("freeze_ptr", 64'(cap_wr_ptr), 64'd10);
        for (int i = 0; i < 20; i++) beat(3, 1, 1, 32'(100 + i));
        chk("freeze_hold_ptr", 64'(cap_wr_ptr), 64'd10);
        rd_addr = 6'd9;
        set_idle();
        step();
        chk("freeze_last_entry", 64'(rd_data), {30'd0, 2'b01, 32'd9});
        pulse_clear();
        chk("clear_frozen", 64'(frozen), 64'd0);
        chk("clear_ptr", 64'(cap_wr_ptr), 64'd0);
        chk("clear_err3", 64'(err_sticky[9 +: 3]), 64'd0);

        // Reset mid-packet
        beat(0, 1, 0, 32'd1);
        chk("pre_reset_in_packet", 64'(in_packet[0]), 64'd1);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(0, 0, 1, 32'd2);
        chk("post_reset_err", 64'(err_sticky[1]), 64'd1);
        chk("post_reset_count", 64'(pkt_count[CNT_W-1:0]), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clear = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) cap_sel = CH_W'($urandom_range(0, NUM_CH - 1));
            rd_addr = AW'($urandom);
            for (int c = 0; c < NUM_CH; c++) begin
                sif.valid[c] = ($urandom_range(0, 1) == 1);
                sif.startofpacket[c] = ($urandom_range(0, 9) < 3);
                sif.endofpacket[c] = ($urandom_range(0, 9) < 3);
                sif.data[c*DATA_W +: DATA_W] = $urandom;
            end
            step();
        end
        clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
